// File: rtl/crc_frame_ctrl.sv
// Frame controller for a serial CRC engine: serializes payload bytes LSB first into the
// engine, then collects the 8-bit CRC it shifts back, flagging underrun and timeout.
module crc_frame_ctrl #(
    parameter int TIMEOUT = 12
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [3:0] FRAME_LEN,
    input  logic [7:0] IN_DATA,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic       ENG_RST_N,
    output logic       ENG_ACTIVE,
    output logic       ENG_DATA,
    input  logic       ENG_CRC,
    input  logic       ENG_VALID,
    output logic [7:0] CRC_OUT,
    output logic       DONE,
    output logic       ERR,
    output logic       BUSY
);

    localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CLR, SHIFT, COLLECT, FIN} state_t;

    state_t        state, state_nx;
    logic [3:0]    len_q, acc_cnt, samp_cnt;
    logic [7:0]    hold_q, shift_q, shift_nx, crc_q;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          hold_full, load_shift, fin_err;
    logic          done_q, err_q, eng_rst_n_q, eng_active_q, eng_data_q;
    logic          accept, start_ok, start_zero, bytes_left, have_byte, last_sample;

    assign IN_READY    = ((state == CLR) || (state == SHIFT)) && !hold_full && (acc_cnt < len_q);
    assign accept      = IN_VALID && IN_READY;
    assign start_ok    = START && (FRAME_LEN != 4'd0);
    assign start_zero  = START && (FRAME_LEN == 4'd0);
    // A byte is still owed while the hold is occupied or the host has not delivered them all.
    assign bytes_left  = hold_full || (acc_cnt < len_q);
    assign have_byte   = hold_full || accept;
    assign last_sample = ENG_VALID && (samp_cnt == 4'd7);

    always_comb begin
        // NOTE: every signal written here gets a default first; a branch that skips one would infer a latch.
        state_nx   = state;
        shift_nx   = shift_q;
        load_shift = 1'b0;
        fin_err    = 1'b1;
        case (state)
            IDLE: begin
                if (start_ok) state_nx = CLR;
            end
            CLR: begin
                if (hold_full) begin
                    state_nx   = SHIFT;
                    shift_nx   = hold_q;
                    load_shift = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_cnt != 3'd7) begin
                    shift_nx = {1'b0, shift_q[7:1]};
                end else if (!bytes_left) begin
                    state_nx = COLLECT;
                end else if (have_byte) begin
                    // Reload without a gap; a byte arriving this very cycle bypasses the hold.
                    shift_nx   = hold_full ? hold_q : IN_DATA;
                    load_shift = 1'b1;
                end else begin
                    state_nx = FIN;
                end
            end
            COLLECT: begin
                if (last_sample) begin
                    state_nx = FIN;
                    fin_err  = 1'b0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nx = FIN;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            // NOTE: the hold and shift data registers are reset too, so nothing stale can leak onto ENG_DATA.
            len_q        <= 4'd0;
            acc_cnt      <= 4'd0;
            samp_cnt     <= 4'd0;
            hold_q       <= 8'h00;
            hold_full    <= 1'b0;
            shift_q      <= 8'h00;
            bit_cnt      <= 3'd0;
            tmo_cnt      <= '0;
            crc_q        <= 8'h00;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            eng_rst_n_q  <= 1'b0;
            eng_active_q <= 1'b0;
            eng_data_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here sees pre-edge values of the others.
            eng_rst_n_q  <= (state_nx == SHIFT) || (state_nx == COLLECT);
            eng_active_q <= (state_nx == SHIFT);
            eng_data_q   <= (state_nx == SHIFT) && shift_nx[0];
            done_q       <= (state_nx == FIN) || ((state == IDLE) && start_zero);
            shift_q      <= shift_nx;
            acc_cnt      <= acc_cnt + {3'd0, accept};

            if (load_shift)           bit_cnt <= 3'd0;
            else if (state == SHIFT)  bit_cnt <= bit_cnt + 3'd1;

            if (load_shift) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_q    <= IN_DATA;
                hold_full <= 1'b1;
            end

            if (state == COLLECT) begin
                tmo_cnt <= tmo_cnt + TW'(1);
                if (ENG_VALID) begin
                    crc_q    <= {ENG_CRC, crc_q[7:1]};
                    samp_cnt <= samp_cnt + 4'd1;
                end
            end

            if (state == IDLE) begin
                if (start_ok) begin
                    len_q     <= FRAME_LEN;
                    acc_cnt   <= 4'd0;
                    hold_full <= 1'b0;
                    samp_cnt  <= 4'd0;
                    tmo_cnt   <= '0;
                    crc_q     <= 8'h00;
                    err_q     <= 1'b0;
                end else if (start_zero) begin
                    err_q <= 1'b1;
                end
            end

            if (state_nx == FIN) err_q <= fin_err;
        end
    end

    assign ENG_RST_N  = eng_rst_n_q;
    assign ENG_ACTIVE = eng_active_q;
    assign ENG_DATA   = eng_data_q;
    assign CRC_OUT    = crc_q;
    assign DONE       = done_q;
    assign ERR        = err_q;
    assign BUSY       = (state != IDLE);

endmodule

// File: doc/crc_frame_ctrl.md
CRC_FRAME_CTRL -- requirements
Module: crc_frame_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 12, max COLLECT cycles allowed to obtain 8 CRC bits.
REQ-002 CLK  in  1  rising-edge clock.
REQ-003 RST  in  1  reset, asynchronous, active-low.
REQ-004 START  in  1  frame-start pulse, sampled in IDLE only.
REQ-005 FRAME_LEN  in  4  frame byte count, latched on accepted START.
REQ-006 IN_DATA  in  8  payload byte, serialized LSB first.
REQ-007 IN_VALID / IN_READY  in / out  1 / 1  byte handshake; transfer when both are 1 at a clock edge.
REQ-008 ENG_RST_N  out  1  registered active-low reset to the serial CRC engine.
REQ-009 ENG_ACTIVE / ENG_DATA  out  1 / 1  engine shift enable and serial data bit, both registered.
REQ-010 ENG_CRC / ENG_VALID  in  1 / 1  engine serial CRC bit and its qualifier.
REQ-011 CRC_OUT  out  8  collected CRC byte, first received bit in bit 0.
REQ-012 DONE  out  1  one-cycle frame-complete pulse.
REQ-013 ERR  out  1  qualifies DONE; 1 = underrun or timeout.
REQ-014 BUSY  out  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, CLR, SHIFT, COLLECT, FIN.
REQ-016 IDLE: ENG_RST_N=0, ENG_ACTIVE=0; START=1 with FRAME_LEN!=0 latches length and goes to CLR; START with FRAME_LEN=0 gives DONE=1, ERR=1 for one cycle and stays IDLE.
REQ-017 One-byte hold register feeds an 8-bit shift register; IN_READY=1 iff hold empty, state is CLR or SHIFT, and accepted bytes < latched length.
REQ-018 CLR: ENG_RST_N held 0 until hold is full; no timeout; then SHIFT with ENG_RST_N=1 from the next edge.
REQ-019 SHIFT: ENG_ACTIVE=1 every cycle, ENG_DATA = shift[0], shift right once per cycle, bit counter 0..7.
REQ-020 At bit 7, if bytes remain: hold moves to shift in the same edge (ACTIVE stays 1, no gap); a hold written in the same cycle counts as full.
REQ-021 At bit 7 with bytes remaining and hold empty: underrun; go to FIN with ERR=1, ENG_RST_N=0 from next edge.
REQ-022 At bit 7 of last byte: next state COLLECT, ENG_ACTIVE=0 from next edge; total ACTIVE-high cycles = 8*FRAME_LEN exactly.
REQ-023 COLLECT: on each edge with ENG_VALID=1, CRC_OUT <= {ENG_CRC, CRC_OUT[7:1]} and sample count +1; after 8 samples go to FIN, ERR=0.
REQ-024 COLLECT lasting TIMEOUT cycles without 8 samples: FIN with ERR=1, CRC_OUT holds partial value.
REQ-025 FIN: DONE=1 for exactly one cycle, ENG_RST_N=0, then IDLE; CRC_OUT and ERR hold until next accepted START.
REQ-026 START outside IDLE is ignored; FRAME_LEN changes after latch are ignored.
REQ-027 Sample count 4 bits, byte counter 4 bits, no wrap: max frame 15 bytes.
REQ-028 ENG_RST_N=1 only in SHIFT and COLLECT, so engine is reseeded before every frame.

Reset
REQ-029 RST=0 asynchronously forces: state IDLE, ENG_RST_N=0, ENG_ACTIVE=0, ENG_DATA=0, IN_READY=0, CRC_OUT=8'h00, DONE=0, ERR=0, BUSY=0, hold empty, all counters 0.
REQ-030 Reset mid-frame discards the frame; no DONE is produced for it.

Verification
REQ-031 FRAME_LEN=1, byte 8'h01 ready -> ENG_ACTIVE high 8 consecutive cycles, ENG_DATA 1,0,0,0,0,0,0,0; CRC_OUT matches engine model (seed 8'hD8); DONE with ERR=0.
REQ-032 FRAME_LEN=2, IN_VALID held 1 -> ENG_ACTIVE high exactly 16 contiguous cycles; exactly 2 handshakes; DONE once, ERR=0.
REQ-033 FRAME_LEN=2, second byte withheld past bit 7 -> DONE=1, ERR=1; ENG_RST_N=0 the cycle after bit 7; BUSY=0 after.
REQ-034 Engine stub never asserts ENG_VALID -> DONE=1, ERR=1 exactly TIMEOUT=12 cycles after COLLECT entry.
REQ-035 START with FRAME_LEN=0 -> one-cycle DONE=1, ERR=1, BUSY stays 0; START pulsed during SHIFT -> no effect.
REQ-036 RST asserted in SHIFT of a 3-byte frame -> all outputs at reset values immediately; next frame completes with correct CRC.
